// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - key input and round-key stream bundle for aes_key_expander
interface aes_key_expander_if #(
  parameter int KEY_BITS = 128
);
  logic [KEY_BITS-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic [127:0]        rk_data;
  logic                rk_valid;
  logic                rk_ready;
  logic [3:0]          rk_index;
  logic                rk_last;
  logic                busy;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_data, rk_valid, rk_index, rk_last, busy
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_data, rk_valid, rk_index, rk_last, busy
  );
endinterface

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128/192/256 key schedule, one word per cycle
// Round keys stream out over a valid/ready port; aes_sbox is the shared forward S-box.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Entry 0 sits in the top byte, so byte a lives at bit offset 8*(255-a).
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input logic               clk,
  input logic               reset,
  aes_key_expander_if.slave bus
);
  localparam int         NK     = KEY_BITS / 32;
  localparam int         NR     = NK + 6;
  localparam logic [5:0] NK_I   = 6'(NK);
  localparam logic [5:0] LAST_I = 6'(4 * NR + 3);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [31:0]  win [8];
  logic [31:0]  grp [3];
  logic [5:0]   i;
  logic [7:0]   rcon;
  logic [127:0] rk_data_q;
  logic [3:0]   rk_index_q;
  logic         rk_valid_q, rk_last_q;

  logic [255:0] key_pad;
  logic         stall, advance, rot_step, sub_step;
  logic [31:0]  prev_w, sb_in, sb_out, t_mix, new_w, cur_w;

  assign key_pad = 256'(bus.key_in) << (256 - KEY_BITS);

  assign stall    = rk_valid_q && !bus.rk_ready;
  assign advance  = (state == GEN) && !stall;
  // The window's newest word is w[i-1] and its oldest is w[i-Nk].
  assign prev_w   = win[NK-1];
  assign rot_step = (i >= NK_I) && ((i % NK_I) == 6'd0);
  assign sub_step = (NK == 8) && (i >= NK_I) && (i[2:0] == 3'd4);
  assign sb_in    = rot_step ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[8*b +: 8]), .y(sb_out[8*b +: 8]));
  end

  always_comb begin
    t_mix = prev_w;
    if (rot_step)      t_mix = sb_out ^ {rcon, 24'h0};
    else if (sub_step) t_mix = sb_out;
  end

  assign new_w = win[0] ^ t_mix;
  assign cur_w = (i < NK_I) ? win[i[2:0]] : new_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.key_valid) state_nxt = GEN;
      GEN:     if (advance && i == LAST_I) state_nxt = DRAIN;
      DRAIN:   if (bus.rk_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 8; j++) win[j] <= '0;
      for (int j = 0; j < 3; j++) grp[j] <= '0;
      i          <= '0;
      rcon       <= 8'h01;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      rk_last_q  <= 1'b0;
      rk_valid_q <= 1'b0;
    end else begin
      if (rk_valid_q && bus.rk_ready) rk_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            for (int j = 0; j < 8; j++) win[j] <= key_pad[255-32*j -: 32];
            i    <= '0;
            rcon <= 8'h01;
          end
        end
        GEN: begin
          if (advance) begin
            i <= i + 6'd1;
            // Key words are read in place; the window only slides once derived words start.
            if (i >= NK_I) begin
              for (int j = 0; j < 7; j++) begin
                if (j < NK - 1) win[j] <= win[j+1];
              end
              win[NK-1] <= new_w;
            end
            if (rot_step) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (i[1:0] == 2'd3) begin
              rk_data_q  <= {grp[0], grp[1], grp[2], cur_w};
              rk_index_q <= i[5:2];
              rk_last_q  <= (i == LAST_I);
              rk_valid_q <= 1'b1;
            end else begin
              grp[i[1:0]] <= cur_w;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.key_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rk_data   = rk_data_q;
  assign bus.rk_index  = rk_index_q;
  assign bus.rk_last   = rk_last_q;
  assign bus.rk_valid  = rk_valid_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - scoreboard bench for aes_key_expander at 128/192/256 bits
`timescale 1ns/1ps
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_key_expander_if #(.KEY_BITS(128)) b0 ();
  aes_key_expander_if #(.KEY_BITS(192)) b1 ();
  aes_key_expander_if #(.KEY_BITS(256)) b2 ();

  aes_key_expander #(.KEY_BITS(128)) u0 (.clk(clk), .reset(reset), .bus(b0));
  aes_key_expander #(.KEY_BITS(192)) u1 (.clk(clk), .reset(reset), .bus(b1));
  aes_key_expander #(.KEY_BITS(256)) u2 (.clk(clk), .reset(reset), .bus(b2));

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   idx;
    logic         last;
    logic         chk;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   checks = 0;
  int   errors = 0;
  int   beats0 = 0;
  logic bp_mode = 1'b0;
  int   low_run = 0;
  logic         prev_stall;
  logic [127:0] prev_d;
  logic [3:0]   prev_idx;
  logic [127:0] fips [11];
  logic [127:0] zk [11];

  assign b1.rk_ready = 1'b1;
  assign b2.rk_ready = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int inst, input int r, input logic [127:0] d, input bit chk, input int nr);
    exp_t e;
    e.d = d; e.idx = 4'(r); e.last = (r == nr); e.chk = chk;
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic push128(input bit zero_key);
    for (int r = 0; r < 11; r++) push_exp(0, r, zero_key ? zk[r] : fips[r], 1'b1, 10);
  endtask

  task automatic take(input int inst, input logic [127:0] d, input logic [3:0] idx, input logic last);
    exp_t e;
    bit   empty;
    case (inst)
      0:       empty = (q0.size() == 0);
      1:       empty = (q1.size() == 0);
      default: empty = (q2.size() == 0);
    endcase
    if (empty) begin
      checks++; errors++;
      $display("FAIL beat%0d_unexpected: got index %0d, no beat expected", inst, idx);
      return;
    end
    case (inst)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    if (e.chk) check($sformatf("rk_data%0d_r%0d", inst, e.idx), d, e.d);
    check($sformatf("rk_index%0d", inst), 128'(idx), 128'(e.idx));
    check($sformatf("rk_last%0d_r%0d", inst, e.idx), 128'(last), 128'(e.last));
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode && low_run < 10 && $urandom_range(0, 1) == 0) begin
      b0.rk_ready = 1'b0;
      low_run++;
    end else begin
      b0.rk_ready = 1'b1;
      low_run = 0;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks hold-stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 128'(b0.rk_valid), 128'(1));
        check("stall_data", b0.rk_data, prev_d);
        check("stall_index", 128'(b0.rk_index), 128'(prev_idx));
      end
      prev_stall <= b0.rk_valid && !b0.rk_ready;
      prev_d     <= b0.rk_data;
      prev_idx   <= b0.rk_index;
      if (b0.rk_valid && b0.rk_ready) begin
        take(0, b0.rk_data, b0.rk_index, b0.rk_last);
        beats0 <= beats0 + 1;
      end
      if (b1.rk_valid && b1.rk_ready) take(1, b1.rk_data, b1.rk_index, b1.rk_last);
      if (b2.rk_valid && b2.rk_ready) take(2, b2.rk_data, b2.rk_index, b2.rk_last);
    end
  end

  task automatic start128(input logic [127:0] k);
    b0.key_in    = k;
    b0.key_valid = 1'b1;
    @(posedge clk); #1;
    b0.key_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!(b0.key_ready && b1.key_ready && b2.key_ready &&
             q0.size() == 0 && q1.size() == 0 && q2.size() == 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d/%0d/%0d beats outstanding after %0d cycles, required 0",
               name, q0.size(), q1.size(), q2.size(), n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rk_data"}, b0.rk_data, 128'h0);
    check({name, "_rk_valid"}, 128'(b0.rk_valid), 128'(0));
    check({name, "_rk_index"}, 128'(b0.rk_index), 128'(0));
    check({name, "_rk_last"}, 128'(b0.rk_last), 128'(0));
    check({name, "_busy"}, 128'(b0.busy), 128'(0));
    check({name, "_key_ready"}, 128'(b0.key_ready), 128'(1));
  endtask

  initial begin
    int first, fin, base, n;
    fips = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
             128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
             128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
             128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
             128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    zk   = '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
             128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
             128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
             128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
             128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
             128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    reset = 1'b1;
    b0.key_valid = 1'b0; b0.key_in = '0;
    b1.key_valid = 1'b0; b1.key_in = '0;
    b2.key_valid = 1'b0; b2.key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_key_ready192", 128'(b1.key_ready), 128'(1));
    check("reset_busy256", 128'(b2.busy), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // AES-128 with latency measured from the accepting edge.
    push128(1'b0);
    start128(FIPS_KEY);
    first = 0; fin = 0;
    for (int k = 1; k <= 200 && fin == 0; k++) begin
      @(posedge clk); #1;
      if (b0.rk_valid && first == 0) first = k;
      if (b0.rk_valid && b0.rk_last) fin = k;
    end
    check("latency_round0", 128'(first), 128'(4));
    check("latency_final", 128'(fin), 128'(44));
    @(posedge clk); #1;
    check("after_last_key_ready", 128'(b0.key_ready), 128'(1));
    wait_done("aes128", 300);

    // AES-192 and AES-256 together.
    for (int r = 0; r < 13; r++)
      push_exp(1, r, (r == 0) ? 128'h8e73b0f7da0e6452c810f32b809079e5
                              : 128'he98ba06f448c773c8ecc720401002202, (r == 0 || r == 12), 12);
    for (int r = 0; r < 15; r++)
      push_exp(2, r, (r == 0) ? 128'h603deb1015ca71be2b73aef0857d7781 :
                     (r == 1) ? 128'h1f352c073b6108d72d9810a30914dff4
                              : 128'hfe4890d1e6188d0b046df344706c631e, (r <= 1 || r == 14), 14);
    b1.key_in = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    b2.key_in = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    b1.key_valid = 1'b1; b2.key_valid = 1'b1;
    @(posedge clk); #1;
    b1.key_valid = 1'b0; b2.key_valid = 1'b0;
    wait_done("aes192_256", 400);

    // Back-pressure on the 128-bit engine.
    bp_mode = 1'b1;
    push128(1'b0);
    start128(FIPS_KEY);
    wait_done("backpressure", 2000);
    bp_mode = 1'b0;
    @(posedge clk); #1;

    // Second key offered mid-expansion must wait for the first to finish.
    push128(1'b0);
    push128(1'b1);
    start128(FIPS_KEY);
    repeat (5) @(posedge clk);
    #1;
    b0.key_in = '0;
    b0.key_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("busy_key_ready", 128'(b0.key_ready), 128'(0));
      @(posedge clk); #1;
    end
    b0.key_valid = 1'b0;
    n = 0;
    while (!b0.key_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_released", 128'(b0.key_ready), 128'(1));
    check("busy_first_drained", 128'(q0.size()), 128'(11));
    start128(128'h0);
    wait_done("second_key", 300);

    // Asynchronous reset after the round-3 transfer, with a key offered during reset.
    push128(1'b0);
    base = beats0;
    start128(FIPS_KEY);
    n = 0;
    while (beats0 < base + 4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_reached_round3", 128'(beats0 - base), 128'(4));
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    q0.delete();
    b0.key_in = FIPS_KEY;
    b0.key_valid = 1'b1;
    @(posedge clk); #1;
    b0.key_valid = 1'b0;
    check("reset_beats_key_busy", 128'(b0.busy), 128'(0));
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_reset_outputs("postreset");
    push128(1'b0);
    start128(FIPS_KEY);
    wait_done("after_reset", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Parametrised, iterative AES key-schedule engine supporting AES-128, AES-192 and AES-256. It replaces the fixed chain of per-round key-generation instances, which was 128-bit only, with one sequential engine. The engine generates one 32-bit schedule word per cycle from a sliding window of the last Nk words. It streams Nr+1 128-bit round keys (round 0 to round Nr) over a valid/ready interface to the encryption datapath.

Parameters:
KEY_BITS, 128, cipher key width. Legal values are 128, 192 and 256; any other value is an elaboration error. Derived values: Nk = KEY_BITS/32 and Nr = Nk+6 (10, 12 or 14).

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset; clears all state
key_in  input  KEY_BITS  cipher key; key_in[KEY_BITS-1 -: 32] is w[0] (FIPS-197 byte order)
key_valid  input  1  key_in is valid
key_ready  output  1  engine idle and able to accept a key
rk_data  output  128  round key; [127:96]=w[4r], [95:64]=w[4r+1], [63:32]=w[4r+2], [31:0]=w[4r+3]
rk_valid  output  1  rk_data holds a valid round key
rk_ready  input  1  consumer accepts rk_data
rk_index  output  4  round number r of rk_data (0..Nr)
rk_last  output  1  high with rk_valid when rk_index == Nr
busy  output  1  expansion in progress (state != IDLE)

Behaviour:
- Reset values: rk_data=0, rk_valid=0, rk_index=0, rk_last=0, busy=0, key_ready=1. All internal words are 0, word counter i=0, rcon=8'h01, state=IDLE.
- States:
  - IDLE: key_ready=1. When key_valid=1, latch key_in into an 8-word window register, set i=0, rcon=01, and go to GEN.
  - GEN: produce w[i] each cycle that is not stalled.
  - DRAIN: the last key is held until it is accepted; then return to IDLE.
- Keys presented while not in IDLE are not accepted (key_ready=0).
- Word rule for i < Nk: w[i] = key word i.
- Word rule for i >= Nk, with t = w[i-1]:
  - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
  - Else if Nk == 8 and i mod 8 == 4: t = SubWord(t).
  - Then w[i] = w[i-Nk] ^ t.
- SubWord uses four instances of the shared combinational aes_sbox (FIPS-197 forward table).
- Words accumulate 4 at a time. When word 4r+3 is produced, rk_data is loaded with {w[4r]..w[4r+3]}, rk_index=r, rk_last=(r==Nr), and rk_valid=1 on the same edge.
- Stall: no word is generated in a cycle where rk_valid=1 && rk_ready=0. rk_data, rk_index and rk_last are held stable while rk_valid=1 and not accepted.
- Handshake: a beat transfers on an edge with rk_valid && rk_ready. After the transfer, rk_valid drops unless a new group completes on the same edge.
- Latency: with key accepted at edge E0 and rk_ready held high:
  - round key r becomes valid after edge E(4r+4);
  - the final key becomes valid after E(4Nr+4), i.e. 44, 52 or 60 edges;
  - key_ready rises after the edge on which the rk_last beat transfers. There is no idle bubble beyond that edge.
- Counter widths: i is 6 bits (max 59); rk_index never exceeds Nr.
- Reset mid-operation (any state): immediate return to the reset values; no partial round key is emitted afterwards.
- key_valid and reset asserted together: reset wins and the key is not captured.

Test Plan:
- AES-128 with key 2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 -> 11 beats. Round 0 = key. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1 and rk_valid first high after E44.
- KEY_BITS=192 with key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 beats. Round 12 = e98ba06f448c773c8ecc720401002202 with rk_index=12 and rk_last=1.
- KEY_BITS=256 with key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 beats. Round 14 = fe4890d1e6188d0b046df344706c631e.
- Back-pressure: AES-128 vector with rk_ready toggled randomly (held low up to 10 cycles) -> identical 11-key sequence in order, rk_data/rk_index stable while stalled, no beat lost or duplicated.
- Busy rejection: a second key_valid pulse with a different key during GEN -> key_ready=0 throughout and the output sequence is unchanged. After the last beat, key_ready=1 and the second key is accepted and expanded correctly.
- Reset after round-3 transfer: reset pulsed -> all outputs return to reset values asynchronously. A new key applied after reset expands from round 0 with correct values.
